// File: rtl/addsub_16bit_seq.sv
// 16-bit add/subtract built from one 4-bit ripple slice that is reused over four cycles,
// starting with the low nibble and passing the carry between nibbles through a register.
module addsub_16bit_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sub,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        busy,
   output logic        done,
   output logic [15:0] Sum,
   output logic        Ovfl,
   output logic        Zero,
   output logic        Neg
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_reg, state_next;
   logic        accept;
   logic [1:0]  cnt_reg;
   logic        carry_reg;
   logic        sub_reg;
   logic [15:0] a_reg, b_reg;
   logic [15:0] sum_reg;
   logic        ovfl_reg;

   logic [3:0]  a_nib, b_nib, s_nib;
   logic [4:0]  c;

   // Slice operands for the nibble selected by the counter
   assign a_nib = a_reg[{cnt_reg, 2'b00} +: 4];
   assign b_nib = sub_reg ? ~b_reg[{cnt_reg, 2'b00} +: 4] : b_reg[{cnt_reg, 2'b00} +: 4];
   assign c[0]  = carry_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fa
         assign s_nib[gi]  = a_nib[gi] ^ b_nib[gi] ^ c[gi];
         assign c[gi + 1]  = (a_nib[gi] & b_nib[gi]) | (c[gi] & (a_nib[gi] ^ b_nib[gi]));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // A start seen during DONE is taken straight into RUN so back-to-back
   // operations complete every 5 cycles.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt_reg == 2'd3) state_next = DONE;
         end
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= 16'h0000;
         b_reg     <= 16'h0000;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         cnt_reg   <= 2'd0;
         sum_reg   <= 16'h0000;
         ovfl_reg  <= 1'b0;
      end else if (accept) begin
         a_reg     <= A;
         b_reg     <= B;
         sub_reg   <= sub;
         carry_reg <= sub;
         cnt_reg   <= 2'd0;
         ovfl_reg  <= 1'b0;
      end else if (state_reg == RUN) begin
         sum_reg[{cnt_reg, 2'b00} +: 4] <= s_nib;
         carry_reg <= c[4];
         cnt_reg   <= cnt_reg + 2'd1;
         if (cnt_reg == 2'd3) ovfl_reg <= c[3] ^ c[4];
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);
   assign Sum  = sum_reg;
   assign Ovfl = ovfl_reg;
   assign Zero = (sum_reg == 16'h0000);
   assign Neg  = sum_reg[15];

endmodule
